cache_responder: RTL

// - Direct-mapped, write-through, write-allocate cache; responder for the trace-driven request stream
//   (addr / data / mode, mode 1 = write, 0 = read) that issues one request per transaction.
// - Answers each request with data and a hit flag.
// - Services misses and all writes through a req/ack port to backing memory.
// - Sits between the request initiator (trace bench or core) and main memory.

---
 rtl/cache_responder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cache_responder.sv
// -----------------------------------------------------------------------------
// cache_responder
// Direct-mapped, write-through, write-allocate cache with one word per line.
// It accepts one request at a time from an initiator and answers with data and
// a hit flag. Read misses and all writes are forwarded to backing memory over a
// req/ack handshake.
//
// Optional feature macro: CACHE_STATS_EN
//   - Defined:   hit/miss counters that saturate at 32'hFFFFFFFF.
//   - Undefined: both counters are tied to zero and no counter flops exist.
//
// Ports
//   clk, rst_n            rising-edge clock, async active-low reset
//   req_valid/req_ready   request handshake; ready is high only while idle
//   req_mode              1 = write, 0 = read
//   req_addr, req_data    request address and write data
//   rsp_valid             one-cycle response strobe
//   rsp_data, rsp_hit     read data (or echoed write data) and lookup hit flag
//   mem_req/mem_ack       memory handshake; req held until a one-cycle ack
//   mem_we, mem_addr      memory direction and address
//   mem_wdata, mem_rdata  memory write and read data
//   hit_count, miss_count lookup statistics
// -----------------------------------------------------------------------------
module cache_responder #(
   parameter int ADDR_W  = 24,
   parameter int DATA_W  = 24,
   parameter int INDEX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_mode,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_hit,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t              state_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_hit_q;
   logic                mem_req_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;

   // Captured request and lookup result
   logic                mode_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                hit_q;

   // Line storage: only the valid bits are reset
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_mem_q  [LINES];
   logic [DATA_W-1:0]   data_mem_q [LINES];

   logic [INDEX_W-1:0]  idx_s;
   logic [TAG_W-1:0]    tag_s;
   logic                hit_s;
   logic                line_we_s;
   logic [DATA_W-1:0]   line_wdata_s;

   assign idx_s = addr_q[INDEX_W-1:0];
   assign tag_s = addr_q[ADDR_W-1:INDEX_W];
   assign hit_s = valid_q[idx_s] && (tag_mem_q[idx_s] == tag_s);

   // Line update: write-allocate at lookup for writes, fill on read-miss ack
   always_comb begin
      line_we_s    = 1'b0;
      line_wdata_s = data_q;
      if (state_q == LOOKUP && mode_q) begin
         line_we_s    = 1'b1;
         line_wdata_s = data_q;
      end else if (state_q == MEM_RD && mem_ack) begin
         line_we_s    = 1'b1;
         line_wdata_s = mem_rdata;
      end else begin
         line_we_s    = 1'b0;
         line_wdata_s = data_q;
      end
   end

   // Control FSM with registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_hit_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mode_q      <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
         hit_q       <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  mode_q      <= req_mode;
                  addr_q      <= req_addr;
                  data_q      <= req_data;
                  req_ready_q <= 1'b0;
                  state_q     <= LOOKUP;
               end
            end
            LOOKUP: begin
               hit_q <= hit_s;
               if (mode_q) begin
                  // Write-through: every write goes to memory, hit or not
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= addr_q;
                  mem_wdata_q <= data_q;
                  state_q     <= MEM_WR;
               end else if (hit_s) begin
                  rsp_data_q  <= data_mem_q[idx_s];
                  state_q     <= RESP;
               end else begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= addr_q;
                  state_q     <= MEM_RD;
               end
            end
            MEM_RD: begin
               if (mem_ack) begin
                  mem_req_q  <= 1'b0;
                  rsp_data_q <= mem_rdata;
                  state_q    <= RESP;
               end
            end
            MEM_WR: begin
               if (mem_ack) begin
                  mem_req_q  <= 1'b0;
                  rsp_data_q <= data_q;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               rsp_valid_q <= 1'b1;
               rsp_hit_q   <= hit_q;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               mem_req_q   <= 1'b0;
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   // Valid bits: cleared by reset, set whenever a line is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (line_we_s) begin
         valid_q[idx_s] <= 1'b1;
      end
   end

   // Tag and data arrays; a conflicting tag simply overwrites the line
   always_ff @(posedge clk) begin
      if (line_we_s) begin
         tag_mem_q[idx_s]  <= tag_s;
         data_mem_q[idx_s] <= line_wdata_s;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating lookup statistics, reads and writes alike
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_q  <= 32'd0;
         miss_cnt_q <= 32'd0;
      end else if (state_q == LOOKUP) begin
         if (hit_s) begin
            if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   assign hit_count  = 32'd0;
   assign miss_count = 32'd0;
`endif

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_hit   = rsp_hit_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
